// File: rtl/mac_requant.sv
// Requantizer behind the MAC: bias add, rounding right shift, unsigned clamp,
// then a small output FIFO with credit-based backpressure toward the MAC.
module mac_requant #(
    parameter int ACC_WIDTH   = 22,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_mem,
    input  logic [ACC_WIDTH-1:0]              acc_in,
    input  logic                              acc_valid,
    output logic                              acc_ready,
    input  logic [ACC_WIDTH:0]                bias_in,
    input  logic [SHIFT_WIDTH-1:0]            shift_in,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              sat_flag,
    input  logic                              clr_sat,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int SUM_W = ACC_WIDTH + 2;
    localparam int EXT_W = ACC_WIDTH + 3;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [SHIFT_WIDTH:0]       MAX_SHIFT = (SHIFT_WIDTH + 1)'(ACC_WIDTH + 1);
    localparam logic signed [EXT_W-1:0]    OUT_MAX   = EXT_W'((1 << OUT_WIDTH) - 1);

    logic                          accept;
    logic                          s1_valid_reg;
    logic signed [SUM_W-1:0]       s1_sum_reg;
    logic signed [SUM_W-1:0]       s1_sum_next;
    logic [SHIFT_WIDTH-1:0]        s1_shift_reg;
    logic                          s2_valid_reg;
    logic [OUT_WIDTH-1:0]          s2_data_reg;
    logic [OUT_WIDTH-1:0]          s2_data_next;
    logic                          s2_sat_next;
    logic signed [EXT_W-1:0]       sum_ext;
    logic signed [EXT_W-1:0]       rnd_one;
    logic signed [EXT_W-1:0]       rounded;
    logic                          sat_flag_reg;
    logic [OUT_WIDTH-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_reg;
    logic [PTR_W-1:0]              rd_ptr_reg;
    logic [CNT_W-1:0]              count_reg;
    logic [CNT_W:0]                credits_used;
    logic                          push;
    logic                          pop;

    // Credits cover everything already committed downstream, so the FIFO cannot overflow.
    assign credits_used = {1'b0, count_reg} + (CNT_W + 1)'(s1_valid_reg) + (CNT_W + 1)'(s2_valid_reg);
    assign acc_ready    = credits_used < (CNT_W + 1)'(FIFO_DEPTH);
    assign accept       = acc_valid && acc_ready;
    assign s1_sum_next  = $signed({2'b00, acc_in}) + $signed({bias_in[ACC_WIDTH], bias_in});

    always_ff @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            s1_valid_reg <= 1'b0;
            s1_sum_reg   <= '0;
            s1_shift_reg <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_sum_reg   <= s1_sum_next;
                s1_shift_reg <= shift_in;
            end
        end
    end

    // Round-half-up: add half an LSB of the result before the arithmetic shift.
    always_comb begin
        sum_ext      = {s1_sum_reg[SUM_W-1], s1_sum_reg};
        rnd_one      = EXT_W'(1) << (s1_shift_reg - SHIFT_WIDTH'(1));
        rounded      = sum_ext;
        s2_data_next = '0;
        s2_sat_next  = 1'b0;
        if (s1_shift_reg == '0) begin
            rounded = sum_ext;
        end else if ({1'b0, s1_shift_reg} <= MAX_SHIFT) begin
            rounded = (sum_ext + rnd_one) >>> s1_shift_reg;
        end else begin
            rounded = '0;
        end
        if (rounded[EXT_W-1]) begin
            s2_data_next = '0;
        end else if (rounded > OUT_MAX) begin
            s2_data_next = '1;
            s2_sat_next  = 1'b1;
        end else begin
            s2_data_next = rounded[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            sat_flag_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= s2_data_next;
            end
            if (s1_valid_reg && s2_sat_next) begin
                sat_flag_reg <= 1'b1;
            end else if (clr_sat) begin
                sat_flag_reg <= 1'b0;
            end
        end
    end

    assign push = s2_valid_reg;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= s2_data_reg;
        end
    end

    always_ff @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is gated by occupancy so an empty or freshly reset FIFO shows zero.
    assign out_valid  = (count_reg != '0);
    assign out_data   = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign fifo_count = count_reg;
    assign sat_flag   = sat_flag_reg;

endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: a queue-based reference model checked every
// cycle, plus hand-computed expected activations for each scenario.
module tb_mac_requant;
    logic        clk = 1'b0;
    logic        rst_mem;
    logic [21:0] acc_in;
    logic        acc_valid;
    logic        acc_ready;
    logic [22:0] bias_in;
    logic [4:0]  shift_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_flag;
    logic        clr_sat;
    logic [2:0]  fifo_count;

    mac_requant dut (
        .clk(clk), .rst_mem(rst_mem), .acc_in(acc_in), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .bias_in(bias_in), .shift_in(shift_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag), .clr_sat(clr_sat), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit sat;
        int age;
    } flight_t;

    flight_t infl[$];
    int      exp_q[$];
    int      got[$];
    bit      flag_m;
    int      total = 0;
    int      bad   = 0;
    int      idx;
    int      cnt_ref;
    bit      acc_now;
    bit      do_pop;
    bit      set_now;
    bit      will_accept;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_ready();
        return (exp_q.size() + infl.size()) < 4;
    endfunction

    // Reference arithmetic straight from the requantization rules.
    function automatic void ref_calc(input longint acc, input longint bias, input int sh,
                                     output int val, output bit sat);
        longint s;
        longint r;
        s = acc + bias;
        if (sh == 0)       r = s;
        else if (sh <= 23) r = (s + (longint'(1) << (sh - 1))) >>> sh;
        else               r = 0;
        sat = 1'b0;
        if (r < 0) val = 0;
        else if (r > 255) begin val = 255; sat = 1'b1; end
        else val = int'(r);
    endfunction

    // Model: results take two edges to reach the FIFO; sat is seen one edge after acceptance.
    always @(posedge clk or posedge rst_mem) begin
        if (rst_mem) begin
            exp_q.delete();
            infl.delete();
            flag_m = 1'b0;
        end else begin
            acc_now = acc_valid && m_ready();
            do_pop  = (exp_q.size() > 0) && out_ready;
            set_now = 1'b0;
            if (do_pop) void'(exp_q.pop_front());
            foreach (infl[i]) begin
                infl[i].age++;
                if (infl[i].age == 1 && infl[i].sat) set_now = 1'b1;
            end
            if (infl.size() > 0 && infl[0].age == 2) begin
                exp_q.push_back(infl[0].val);
                void'(infl.pop_front());
            end
            flag_m = set_now ? 1'b1 : (clr_sat ? 1'b0 : flag_m);
            if (acc_now) begin
                flight_t f;
                ref_calc(longint'(acc_in), longint'($signed(bias_in)), int'(shift_in), f.val, f.sat);
                f.age = 0;
                infl.push_back(f);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_mem && out_valid && out_ready) got.push_back(int'(out_data));
    end

    always @(negedge clk) begin
        if (!rst_mem) begin
            chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("out_data", int'(out_data), exp_q[0]);
            chk("fifo_count", int'(fifo_count), exp_q.size());
            chk("acc_ready", int'(acc_ready), int'(m_ready()));
            chk("sat_flag", int'(sat_flag), int'(flag_m));
        end
    end

    task automatic send(input int acc, input int bias, input int sh);
        int waited;
        waited = 0;
        while (!m_ready() && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) chk("send_timeout", 0, 1);
        acc_valid = 1'b1;
        acc_in    = 22'(acc);
        bias_in   = 23'(bias);
        shift_in  = 5'(sh);
        $display("send acc=%0d bias=%0d shift=%0d", acc, bias, sh);
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_got(input string name, input int v);
        if (got.size() == 0) begin
            chk({name, "_missing"}, -1, v);
        end else begin
            int g;
            g = got.pop_front();
            $display("result %s = %0d", name, g);
            chk(name, g, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_mem = 1'b1; acc_valid = 1'b0; acc_in = '0; bias_in = '0; shift_in = '0;
        out_ready = 1'b1; clr_sat = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        chk("rst_acc_ready", int'(acc_ready), 1);
        @(negedge clk);
        rst_mem = 1'b0;
        idle(2);

        // Basic rounding with latency check
        send(1000, 0, 2);
        chk("lat_c1", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_c2", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_c3_valid", int'(out_valid), 1);
        chk("lat_c3_data", int'(out_data), 250);
        send(6, 0, 2);
        send(5, 0, 1);
        idle(5);
        expect_got("r1000_s2", 250);
        expect_got("r6_s2", 2);
        expect_got("r5_s1", 3);
        chk("basic_sat", int'(sat_flag), 0);

        // Bias and negative clamp
        send(1000, -500, 1);
        send(10, -100, 0);
        send(4194303, -4194303, 0);
        idle(5);
        expect_got("bias_pos", 250);
        expect_got("bias_neg", 0);
        expect_got("bias_zero", 0);
        chk("neg_sat", int'(sat_flag), 0);

        // Saturation and sticky flag
        send(5000, 0, 0);
        idle(4);
        expect_got("sat_255", 255);
        chk("sat_set", int'(sat_flag), 1);
        send(100, 0, 0);
        idle(4);
        expect_got("after_sat", 100);
        chk("sat_sticky", int'(sat_flag), 1);
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        chk("sat_cleared", int'(sat_flag), 0);
        send(5000, 0, 0);
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        chk("sat_set_wins", int'(sat_flag), 1);
        idle(4);
        expect_got("sat_again", 255);

        // Large shift
        send(4194303, 4194303, 23);
        send(4194303, 4194303, 24);
        send(4194303, 4194303, 31);
        idle(5);
        expect_got("shift23", 1);
        expect_got("shift24", 0);
        expect_got("shift31", 0);

        // Backpressure with out_ready low
        out_ready = 1'b0;
        shift_in = '0; bias_in = '0;
        idx = 1;
        repeat (10) begin
            acc_valid = 1'b1; acc_in = 22'(idx);
            will_accept = m_ready();
            @(negedge clk);
            if (will_accept) idx++;
        end
        chk("bp_accepted", idx - 1, 4);
        chk("bp_count", int'(fifo_count), 4);
        chk("bp_ready", int'(acc_ready), 0);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && idx <= 6; c++) begin
            acc_valid = 1'b1; acc_in = 22'(idx);
            will_accept = m_ready();
            @(negedge clk);
            if (will_accept) idx++;
        end
        acc_valid = 1'b0;
        idle(6);
        for (int v = 1; v <= 6; v++) expect_got($sformatf("bp_%0d", v), v);

        // Continuous throughput
        for (int v = 20; v < 30; v++) begin
            acc_valid = 1'b1; acc_in = 22'(v);
            @(negedge clk);
            if (v >= 23) begin
                chk("thru_valid", int'(out_valid), 1);
                chk("thru_count", int'(fifo_count), 1);
            end
        end
        acc_valid = 1'b0;
        idle(5);
        for (int v = 20; v < 30; v++) expect_got($sformatf("thru_%0d", v), v);

        // Reset mid-operation: 2 in FIFO, S1 and S2 occupied
        out_ready = 1'b0;
        for (int v = 0; v < 4; v++) begin
            acc_valid = 1'b1; acc_in = (v == 0) ? 22'd300 : 22'(v + 40);
            @(negedge clk);
        end
        acc_valid = 1'b0;
        chk("pre_rst_count", int'(fifo_count), 2);
        chk("pre_rst_sat", int'(sat_flag), 1);
        #2 rst_mem = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_count", int'(fifo_count), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_sat", int'(sat_flag), 0);
        chk("mid_rst_ready", int'(acc_ready), 1);
        got.delete();
        @(negedge clk);
        rst_mem = 1'b0;
        out_ready = 1'b1;
        idle(2);
        chk("post_rst_empty", int'(out_valid), 0);
        send(1000, 0, 2);
        @(negedge clk);
        chk("post_rst_c2", int'(out_valid), 0);
        @(negedge clk);
        chk("post_rst_c3", int'(out_valid), 1);
        chk("post_rst_data", int'(out_data), 250);
        idle(4);
        expect_got("post_rst", 250);
        chk("post_rst_no_stale", got.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
